axi_slice_cfg: RTL and testbench
================================

// Module: axi_slice_cfg
// PURPOSE
//  Parametrised AXI4 register slice sitting between an AXI master (s_* side) and a slave/interconnect (m_* side).
//  Breaks timing on all five channels (AW, W, B, AR, R); each channel has its own mode: bypass, forward-register or full skid.
//  Payloads travel as packed structs from the shared package; ordering is preserved on every channel, no beat dropped or duplicated.
// PARAMETERS
//  ADDR_W     32  address width (AWADDR/ARADDR)
//  DATA_W     64  data width (WDATA/RDATA); WSTRB width = DATA_W/8
//  ID_W       4   AWID/ARID/BID/RID width
//  USER_W     1   width of every *USER field
//  AW_MODE    2   0=bypass, 1=forward reg, 2=full skid (likewise W_MODE, B_MODE, AR_MODE, R_MODE; default 2)
//  MAX_OUTST  8   max outstanding AW and AR bursts; used only with AXI_SLICE_OUTST_EN
// PORTS
//  ACLK                 in   1         clock
//  ARESETn              in   1         async active-low reset
//  s_aw_valid/s_aw_pld  in   1/AW_W    master write address; s_aw_ready out 1
//  s_w_valid/s_w_pld    in   1/W_W     master write data (incl. WLAST); s_w_ready out 1
//  s_b_valid/s_b_pld    out  1/B_W     write response to master; s_b_ready in 1
//  s_ar_valid/s_ar_pld  in   1/AR_W    master read address; s_ar_ready out 1
//  s_r_valid/s_r_pld    out  1/R_W     read data to master (incl. RLAST); s_r_ready in 1
//  m_aw_valid/m_aw_pld  out  1/AW_W    to slave; m_aw_ready in 1 (m_w, m_ar likewise out; m_b, m_r in, ready out)
//  aw_outst/ar_outst    out  CNT_W     outstanding counts, CNT_W=$clog2(MAX_OUTST+1); present only with macro
// BEHAVIOUR
//  Clock ACLK; reset ARESETn asynchronous, active-low. Reset: all *_valid=0, all *_ready=0, buffers empty, counters 0.
//  Registered readies rise on the first ACLK edge after ARESETn deasserts; payloads reset to 0.
//  Handshake: beat moves when valid&&ready. Outputs hold valid and payload stable until accepted; valid never drops unaccepted.
//  Mode 0 bypass: combinational wire-through, 0 latency, no state.
//  Mode 1 forward: 1 entry; m_valid registered; s_ready = !full || m_ready (combinational path). Latency 1.
//    Full with m_ready=1 and s_valid=1: pop and push in the same cycle, entry replaced, m_valid stays 1.
//  Mode 2 full skid: 2 entries (main + skid); s_ready and m_valid both registered; latency 1; 1 beat/cycle sustained.
//    States EMPTY->(push)ONE->(push, no pop)TWO; TWO->(pop)ONE; ONE->(pop, no push)EMPTY; ONE with push+pop stays ONE.
//    s_ready=0 exactly in TWO; pop from TWO takes main, skid moves to main.
//  Reset mid-burst: buffered beats discarded, valids drop asynchronously; upstream must also reset.
//  Channels are independent; no W-vs-AW ordering is imposed.
// CONFIGURATION
//  AXI_SLICE_OUTST_EN defined: aw_outst increments on m_aw handshake and decrements on s_b handshake.
//    ar_outst increments on m_ar handshake and decrements on s_r handshake with RLAST=1. Both in the same cycle: count unchanged.
//    At count==MAX_OUTST, m_aw_valid (m_ar_valid) is forced 0 and the beat stays buffered; it is released on the cycle after a decrement.
//    Decrement at 0 never occurs by protocol; saturate at 0.
//  Undefined: no counters, no gating, aw_outst/ar_outst ports absent.
// STRUCTURE
//  Package axi_slice_pkg holds the aw_pld_t, w_pld_t, b_pld_t, ar_pld_t, r_pld_t structs, parameterised via widths.
//    It also holds the slice_mode_e enum (SLICE_BYPASS, SLICE_FWD, SLICE_FULL) and the helpers rlast_of() and wstrb_w().
//  Sub-module axi_slice_chan #(WIDTH, MODE) is a generic one-channel slice, instantiated 5 times (B and R reverse direction).
//  The top level adds only the outstanding-count logic.
// TESTING
//  1 Mode 2 all channels, s_aw_valid held 1 for 16 beats, m_aw_ready=1 -> 16 beats out in order, 1 cycle latency, no bubbles.
//  2 Mode 2, m_ar_ready=0 while 3 beats offered -> 2 captured, s_ar_ready=0 after the 2nd; ready=1 releases A0,A1, then A2 accepted.
//  3 Mode 1 W, full, m_w_ready=1 and s_w_valid=1 same cycle -> pop D0 and push D1 together, m_w_valid stays 1.
//  4 ARESETn pulsed low mid 4-beat R burst with 2 beats buffered -> s_r_valid=0 immediately; no stale beat after release.
//  5 OUTST_EN, MAX_OUTST=2: 3 AWs with no B -> third held at m_aw_valid=0; one B handshake -> third issued next cycle, aw_outst=2.
//  6 Mode 0 all channels: random valid/ready 1000 cycles -> m_* equals s_* every cycle, scoreboard matches.

Source files
------------

// File: rtl/axi_slice_pkg.sv
// Shared types for the AXI4 register slice: channel payload structs at the default
// widths, slice/FSM enums and width helpers used to size the flat payload ports.
package axi_slice_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_ID_W   = 4;
  localparam int AXI_USER_W = 1;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  function automatic int wstrb_w(input int data_w);
    return data_w / 8;
  endfunction

  // AW/AR: id, addr, len(8), size(3), burst(2), lock(1), cache(4), prot(3), qos(4), user
  function automatic int ax_w(input int id_w, input int addr_w, input int user_w);
    return id_w + addr_w + user_w + 25;
  endfunction

  function automatic int w_w(input int data_w, input int user_w);
    return data_w + wstrb_w(data_w) + user_w + 1;
  endfunction

  function automatic int b_w(input int id_w, input int user_w);
    return id_w + user_w + 2;
  endfunction

  function automatic int r_w(input int id_w, input int data_w, input int user_w);
    return id_w + data_w + user_w + 3;
  endfunction

  function automatic slice_mode_e to_mode(input int m);
    case (m)
      0:       return SLICE_BYPASS;
      1:       return SLICE_FWD;
      default: return SLICE_FULL;
    endcase
  endfunction

  localparam int AXI_STRB_W = wstrb_w(AXI_DATA_W);

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            qos;
    logic [AXI_USER_W-1:0] user;
  } aw_pld_t;

  typedef aw_pld_t ar_pld_t;

  // WLAST and RLAST sit in the LSB so the last flag is at bit 0 for any width set.
  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
    logic [AXI_USER_W-1:0] user;
    logic                  last;
  } w_pld_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
  } b_pld_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic [AXI_USER_W-1:0] user;
    logic                  last;
  } r_pld_t;

  function automatic logic rlast_of(input r_pld_t p);
    return p.last;
  endfunction

endpackage

// File: rtl/axi_slice_chan.sv
// Generic one-channel valid/ready slice: bypass wire, single forward register,
// or two-entry full skid buffer with registered ready and valid.
module axi_slice_chan
  import axi_slice_pkg::*;
#(
  parameter int          WIDTH = 8,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_pld,
  output logic             s_ready,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_pld,
  input  logic             m_ready
);

  if (MODE == SLICE_BYPASS) begin : g_bypass
    assign m_valid = s_valid;
    assign m_pld   = s_pld;
    assign s_ready = m_ready;

  end else if (MODE == SLICE_FWD) begin : g_fwd
    logic             full_q;
    logic [WIDTH-1:0] data_q;

    assign s_ready = !full_q || m_ready;
    assign m_valid = full_q;
    assign m_pld   = data_q;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        full_q <= 1'b0;
        data_q <= '0;
      end else if (s_ready) begin
        full_q <= s_valid;
        if (s_valid) data_q <= s_pld;
      end
    end

  end else begin : g_full
    skid_state_e      state;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             ready_q, valid_q;
    logic             push, pop;

    assign push    = s_valid && ready_q;
    assign pop     = valid_q && m_ready;
    assign s_ready = ready_q;
    assign m_valid = valid_q;
    assign m_pld   = main_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
        // NOTE: payload registers are reset as well so outputs read zero out of reset.
        state   <= SKID_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b0;
        valid_q <= 1'b0;
      end else begin
        case (state)
          SKID_EMPTY: begin
            ready_q <= 1'b1;
            if (push) begin
              main_q  <= s_pld;
              valid_q <= 1'b1;
              state   <= SKID_ONE;
            end
          end
          SKID_ONE: begin
            if (push && !pop) begin
              skid_q  <= s_pld;
              ready_q <= 1'b0;
              state   <= SKID_TWO;
            end else if (push) begin
              main_q <= s_pld;
            end else if (pop) begin
              valid_q <= 1'b0;
              state   <= SKID_EMPTY;
            end
          end
          SKID_TWO: begin
            // Oldest beat leaves from main; the parked beat moves up behind it.
            if (pop) begin
              main_q  <= skid_q;
              ready_q <= 1'b1;
              state   <= SKID_ONE;
            end
          end
          default: state <= SKID_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: rtl/axi_slice_cfg.sv
// AXI4 register slice, one axi_slice_chan per channel with a per-channel mode.
// Define AXI_SLICE_OUTST_EN to add outstanding AW/AR burst counters that hold issue at MAX_OUTST.
module axi_slice_cfg
  import axi_slice_pkg::*;
#(
  parameter int  ADDR_W    = AXI_ADDR_W,
  parameter int  DATA_W    = AXI_DATA_W,
  parameter int  ID_W      = AXI_ID_W,
  parameter int  USER_W    = AXI_USER_W,
  parameter int  AW_MODE   = 2,
  parameter int  W_MODE    = 2,
  parameter int  B_MODE    = 2,
  parameter int  AR_MODE   = 2,
  parameter int  R_MODE    = 2,
  parameter int  MAX_OUTST = 8,
  localparam int AW_W      = ax_w(ID_W, ADDR_W, USER_W),
  localparam int W_W       = w_w(DATA_W, USER_W),
  localparam int B_W       = b_w(ID_W, USER_W),
  localparam int AR_W      = ax_w(ID_W, ADDR_W, USER_W),
  localparam int R_W       = r_w(ID_W, DATA_W, USER_W)
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic                               s_aw_valid,
  input  logic [AW_W-1:0]                    s_aw_pld,
  output logic                               s_aw_ready,
  input  logic                               s_w_valid,
  input  logic [W_W-1:0]                     s_w_pld,
  output logic                               s_w_ready,
  output logic                               s_b_valid,
  output logic [B_W-1:0]                     s_b_pld,
  input  logic                               s_b_ready,
  input  logic                               s_ar_valid,
  input  logic [AR_W-1:0]                    s_ar_pld,
  output logic                               s_ar_ready,
  output logic                               s_r_valid,
  output logic [R_W-1:0]                     s_r_pld,
  input  logic                               s_r_ready,
  output logic                               m_aw_valid,
  output logic [AW_W-1:0]                    m_aw_pld,
  input  logic                               m_aw_ready,
  output logic                               m_w_valid,
  output logic [W_W-1:0]                     m_w_pld,
  input  logic                               m_w_ready,
  input  logic                               m_b_valid,
  input  logic [B_W-1:0]                     m_b_pld,
  output logic                               m_b_ready,
  output logic                               m_ar_valid,
  output logic [AR_W-1:0]                    m_ar_pld,
  input  logic                               m_ar_ready,
  input  logic                               m_r_valid,
  input  logic [R_W-1:0]                     m_r_pld,
  output logic                               m_r_ready
`ifdef AXI_SLICE_OUTST_EN
  ,
  output logic [$clog2(MAX_OUTST+1)-1:0]     aw_outst,
  output logic [$clog2(MAX_OUTST+1)-1:0]     ar_outst
`endif
);

  if (MAX_OUTST < 1) begin : g_bad_max_outst
    $error("axi_slice_cfg: MAX_OUTST must be at least 1");
  end

  logic aw_valid_int, aw_ready_int;
  logic ar_valid_int, ar_ready_int;

  axi_slice_chan #(.WIDTH(AW_W), .MODE(to_mode(AW_MODE))) u_aw (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_valid(s_aw_valid), .s_pld(s_aw_pld), .s_ready(s_aw_ready),
    .m_valid(aw_valid_int), .m_pld(m_aw_pld), .m_ready(aw_ready_int)
  );

  axi_slice_chan #(.WIDTH(W_W), .MODE(to_mode(W_MODE))) u_w (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_valid(s_w_valid), .s_pld(s_w_pld), .s_ready(s_w_ready),
    .m_valid(m_w_valid), .m_pld(m_w_pld), .m_ready(m_w_ready)
  );

  // B and R flow slave-to-master, so the m_* side feeds the slice input.
  axi_slice_chan #(.WIDTH(B_W), .MODE(to_mode(B_MODE))) u_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_valid(m_b_valid), .s_pld(m_b_pld), .s_ready(m_b_ready),
    .m_valid(s_b_valid), .m_pld(s_b_pld), .m_ready(s_b_ready)
  );

  axi_slice_chan #(.WIDTH(AR_W), .MODE(to_mode(AR_MODE))) u_ar (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_valid(s_ar_valid), .s_pld(s_ar_pld), .s_ready(s_ar_ready),
    .m_valid(ar_valid_int), .m_pld(m_ar_pld), .m_ready(ar_ready_int)
  );

  axi_slice_chan #(.WIDTH(R_W), .MODE(to_mode(R_MODE))) u_r (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_valid(m_r_valid), .s_pld(m_r_pld), .s_ready(m_r_ready),
    .m_valid(s_r_valid), .m_pld(s_r_pld), .m_ready(s_r_ready)
  );

`ifdef AXI_SLICE_OUTST_EN
  localparam int               CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  logic aw_full, aw_inc, aw_dec;
  logic ar_full, ar_inc, ar_dec;

  // The gate comes from the registered count, so a presented beat is never withdrawn.
  assign aw_full      = (aw_outst == CNT_MAX);
  assign m_aw_valid   = aw_valid_int && !aw_full;
  assign aw_ready_int = m_aw_ready && !aw_full;
  assign aw_inc       = m_aw_valid && m_aw_ready;
  assign aw_dec       = s_b_valid && s_b_ready;

  assign ar_full      = (ar_outst == CNT_MAX);
  assign m_ar_valid   = ar_valid_int && !ar_full;
  assign ar_ready_int = m_ar_ready && !ar_full;
  assign ar_inc       = m_ar_valid && m_ar_ready;
  assign ar_dec       = s_r_valid && s_r_ready && s_r_pld[0];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_outst <= '0;
      ar_outst <= '0;
    end else begin
      if (aw_inc && !aw_dec)                         aw_outst <= aw_outst + 1'b1;
      else if (aw_dec && !aw_inc && aw_outst != '0) aw_outst <= aw_outst - 1'b1;
      if (ar_inc && !ar_dec)                         ar_outst <= ar_outst + 1'b1;
      else if (ar_dec && !ar_inc && ar_outst != '0) ar_outst <= ar_outst - 1'b1;
    end
  end
`else
  assign m_aw_valid   = aw_valid_int;
  assign aw_ready_int = m_aw_ready;
  assign m_ar_valid   = ar_valid_int;
  assign ar_ready_int = m_ar_ready;
`endif

endmodule

// File: tb/tb_axi_slice_cfg.sv
// Directed bench for axi_slice_cfg: three instances (all-skid, all-forward, all-bypass)
// share one clock and reset; outstanding-count steps run when AXI_SLICE_OUTST_EN is defined.
module tb_axi_slice_cfg;
  import axi_slice_pkg::*;

  localparam int AW_W = ax_w(AXI_ID_W, AXI_ADDR_W, AXI_USER_W);
  localparam int W_W  = w_w(AXI_DATA_W, AXI_USER_W);
  localparam int B_W  = b_w(AXI_ID_W, AXI_USER_W);
  localparam int AR_W = ax_w(AXI_ID_W, AXI_ADDR_W, AXI_USER_W);
  localparam int R_W  = r_w(AXI_ID_W, AXI_DATA_W, AXI_USER_W);

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  // Index 0: all channels full skid; 1: all forward; 2: all bypass.
  logic [2:0] s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready;
  logic [2:0] m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid;
  wire  [2:0] s_aw_ready, s_w_ready, s_b_valid, s_ar_ready, s_r_valid;
  wire  [2:0] m_aw_valid, m_w_valid, m_b_ready, m_ar_valid, m_r_ready;
  logic [AW_W-1:0] s_aw_pld [3];
  logic [W_W-1:0]  s_w_pld  [3];
  logic [AR_W-1:0] s_ar_pld [3];
  logic [B_W-1:0]  m_b_pld  [3];
  logic [R_W-1:0]  m_r_pld  [3];
  wire  [AW_W-1:0] m_aw_pld [3];
  wire  [W_W-1:0]  m_w_pld  [3];
  wire  [AR_W-1:0] m_ar_pld [3];
  wire  [B_W-1:0]  s_b_pld  [3];
  wire  [R_W-1:0]  s_r_pld  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int MODE = 2 - g;
    localparam int MAXO = (g == 1) ? 2 : ((g == 0) ? 32 : 1000);
`ifdef AXI_SLICE_OUTST_EN
    wire [$clog2(MAXO+1)-1:0] aw_outst, ar_outst;
`endif
    axi_slice_cfg #(
      .AW_MODE(MODE), .W_MODE(MODE), .B_MODE(MODE), .AR_MODE(MODE), .R_MODE(MODE),
      .MAX_OUTST(MAXO)
    ) u_dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .s_aw_valid(s_aw_valid[g]), .s_aw_pld(s_aw_pld[g]), .s_aw_ready(s_aw_ready[g]),
      .s_w_valid(s_w_valid[g]),   .s_w_pld(s_w_pld[g]),   .s_w_ready(s_w_ready[g]),
      .s_b_valid(s_b_valid[g]),   .s_b_pld(s_b_pld[g]),   .s_b_ready(s_b_ready[g]),
      .s_ar_valid(s_ar_valid[g]), .s_ar_pld(s_ar_pld[g]), .s_ar_ready(s_ar_ready[g]),
      .s_r_valid(s_r_valid[g]),   .s_r_pld(s_r_pld[g]),   .s_r_ready(s_r_ready[g]),
      .m_aw_valid(m_aw_valid[g]), .m_aw_pld(m_aw_pld[g]), .m_aw_ready(m_aw_ready[g]),
      .m_w_valid(m_w_valid[g]),   .m_w_pld(m_w_pld[g]),   .m_w_ready(m_w_ready[g]),
      .m_b_valid(m_b_valid[g]),   .m_b_pld(m_b_pld[g]),   .m_b_ready(m_b_ready[g]),
      .m_ar_valid(m_ar_valid[g]), .m_ar_pld(m_ar_pld[g]), .m_ar_ready(m_ar_ready[g]),
      .m_r_valid(m_r_valid[g]),   .m_r_pld(m_r_pld[g]),   .m_r_ready(m_r_ready[g])
`ifdef AXI_SLICE_OUTST_EN
      ,
      .aw_outst(aw_outst), .ar_outst(ar_outst)
`endif
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  r_pld_t          rp;
  logic [AW_W-1:0] sb_q [$];
  logic [AW_W-1:0] sb_exp;

  initial begin
    ARESETn = 1'b0;
    s_aw_valid = '0; s_w_valid = '0; s_b_ready = '0; s_ar_valid = '0; s_r_ready = '0;
    m_aw_ready = '0; m_w_ready = '0; m_b_valid = '0; m_ar_ready = '0; m_r_valid = '0;
    for (int g = 0; g < 3; g++) begin
      s_aw_pld[g] = '0; s_w_pld[g] = '0; s_ar_pld[g] = '0; m_b_pld[g] = '0; m_r_pld[g] = '0;
    end

    // Reset state
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_s_aw_ready", s_aw_ready[0], 1'b0);
    check("rst_m_aw_valid", m_aw_valid[0], 1'b0);
    check("rst_s_b_valid",  s_b_valid[0],  1'b0);
    check("rst_s_r_valid",  s_r_valid[0],  1'b0);
    check("rst_m_w_valid1", m_w_valid[1],  1'b0);
    check("rst_m_ar_pld",   m_ar_pld[0],   '0);
    @(negedge ACLK) ARESETn = 1'b1;
    #1;
    check("rel_ready_before_edge", s_aw_ready[0], 1'b0);
    tick();
    check("rel_s_aw_ready", s_aw_ready[0], 1'b1);
    check("rel_m_b_ready",  m_b_ready[0],  1'b1);

    // Skid AW stream: 16 beats, one per cycle, one cycle latency
    m_aw_ready[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_aw_valid[0] = 1'b1;
      s_aw_pld[0]   = AW_W'(32'h100 + i);
      #1;
      check("t1_s_aw_ready", s_aw_ready[0], 1'b1);
      tick();
      check("t1_m_aw_valid", m_aw_valid[0], 1'b1);
      check("t1_m_aw_pld",   m_aw_pld[0],   AW_W'(32'h100 + i));
    end
    s_aw_valid[0] = 1'b0;
    tick();
    check("t1_drain", m_aw_valid[0], 1'b0);
    m_aw_ready[0] = 1'b0;

    // Skid AR backpressure: two captured, third waits
    s_ar_valid[0] = 1'b1;
    s_ar_pld[0]   = AR_W'(32'hA0);
    tick();
    check("t2_ready_one", s_ar_ready[0], 1'b1);
    check("t2_pld_a0",    m_ar_pld[0],   AR_W'(32'hA0));
    s_ar_pld[0] = AR_W'(32'hA1);
    tick();
    check("t2_ready_two", s_ar_ready[0], 1'b0);
    s_ar_pld[0] = AR_W'(32'hA2);
    tick();
    check("t2_still_a0",  m_ar_pld[0],   AR_W'(32'hA0));
    check("t2_still_blk", s_ar_ready[0], 1'b0);
    m_ar_ready[0] = 1'b1;
    tick();
    check("t2_pld_a1",   m_ar_pld[0],   AR_W'(32'hA1));
    check("t2_reopened", s_ar_ready[0], 1'b1);
    tick();
    check("t2_valid_a2", m_ar_valid[0], 1'b1);
    check("t2_pld_a2",   m_ar_pld[0],   AR_W'(32'hA2));
    s_ar_valid[0] = 1'b0;
    tick();
    check("t2_empty", m_ar_valid[0], 1'b0);
    m_ar_ready[0] = 1'b0;

    // Forward W: pop and push in the same cycle
    s_w_valid[1] = 1'b1;
    s_w_pld[1]   = W_W'(32'hD0);
    #1;
    check("t3_ready_empty", s_w_ready[1], 1'b1);
    tick();
    check("t3_valid_d0", m_w_valid[1], 1'b1);
    check("t3_pld_d0",   m_w_pld[1],   W_W'(32'hD0));
    check("t3_full_blk", s_w_ready[1], 1'b0);
    m_w_ready[1] = 1'b1;
    s_w_pld[1]   = W_W'(32'hD1);
    #1;
    check("t3_ready_comb", s_w_ready[1], 1'b1);
    tick();
    check("t3_valid_d1", m_w_valid[1], 1'b1);
    check("t3_pld_d1",   m_w_pld[1],   W_W'(32'hD1));
    s_w_valid[1] = 1'b0;
    tick();
    check("t3_empty", m_w_valid[1], 1'b0);
    m_w_ready[1] = 1'b0;

    // Reset in the middle of a 4-beat R burst with two beats buffered
    rp = '0;
    rp.id = 4'h3;
    m_r_valid[0] = 1'b1;
    rp.data = 64'hBEEF_0000; m_r_pld[0] = rp;
    tick();
    rp.data = 64'hBEEF_0001; m_r_pld[0] = rp;
    tick();
    check("t4_valid_r0",    s_r_valid[0], 1'b1);
    check("t4_pld_r0",      s_r_pld[0],   R_W'({4'h3, 64'hBEEF_0000, 4'h0}));
    check("t4_full_nready", m_r_ready[0], 1'b0);
    rp.data = 64'hBEEF_0002; m_r_pld[0] = rp;
    #2;
    ARESETn      = 1'b0;
    m_r_valid[0] = 1'b0;
    #1;
    check("t4_async_valid", s_r_valid[0], 1'b0);
    check("t4_async_pld",   s_r_pld[0],   '0);
    @(negedge ACLK) ARESETn = 1'b1;
    tick();
    tick();
    s_r_ready[0] = 1'b1;
    #1;
    check("t4_no_stale", s_r_valid[0], 1'b0);
    rp.data = 64'hBEEF_0003; rp.last = 1'b1; m_r_pld[0] = rp;
    m_r_valid[0] = 1'b1;
    tick();
    m_r_valid[0] = 1'b0;
    check("t4_fresh_pld", s_r_pld[0], R_W'({4'h3, 64'hBEEF_0003, 4'h1}));
    check("t4_rlast",     rlast_of(r_pld_t'(s_r_pld[0])), 1'b1);
    tick();
    check("t4_drained", s_r_valid[0], 1'b0);
    s_r_ready[0] = 1'b0;

`ifdef AXI_SLICE_OUTST_EN
    // Outstanding limit of 2 on the forward instance
    m_aw_ready[1] = 1'b1;
    s_b_ready[1]  = 1'b1;
    s_aw_valid[1] = 1'b1;
    s_aw_pld[1]   = AW_W'(32'hC0);
    tick();
    s_aw_pld[1] = AW_W'(32'hC1);
    tick();
    check("t5_cnt1", g_dut[1].aw_outst, 2'd1);
    s_aw_pld[1] = AW_W'(32'hC2);
    tick();
    s_aw_valid[1] = 1'b0;
    check("t5_gated",   m_aw_valid[1],      1'b0);
    check("t5_cnt2",    g_dut[1].aw_outst,  2'd2);
    check("t5_s_block", s_aw_ready[1],      1'b0);
    tick();
    check("t5_held", m_aw_valid[1], 1'b0);
    m_b_valid[1] = 1'b1;
    m_b_pld[1]   = B_W'(7'h25);
    tick();
    m_b_valid[1] = 1'b0;
    check("t5_b_out", s_b_valid[1], 1'b1);
    check("t5_still", m_aw_valid[1], 1'b0);
    tick();
    check("t5_cnt_dec",  g_dut[1].aw_outst, 2'd1);
    check("t5_released", m_aw_valid[1],     1'b1);
    check("t5_pld_c2",   m_aw_pld[1],       AW_W'(32'hC2));
    tick();
    check("t5_cnt_back", g_dut[1].aw_outst, 2'd2);
    check("t5_gone",     m_aw_valid[1],     1'b0);
    m_aw_ready[1] = 1'b0;
    s_b_ready[1]  = 1'b0;
`endif

    // Bypass instance: random traffic, outputs track inputs, AW scoreboard
    for (int c = 0; c < 1000; c++) begin
      s_aw_valid[2] = 1'($urandom_range(0, 1));
      s_aw_pld[2]   = AW_W'({$urandom(), $urandom()});
      m_aw_ready[2] = 1'($urandom_range(0, 1));
      s_w_valid[2]  = 1'($urandom_range(0, 1));
      s_w_pld[2]    = W_W'({$urandom(), $urandom(), $urandom()});
      m_w_ready[2]  = 1'($urandom_range(0, 1));
      m_b_valid[2]  = 1'($urandom_range(0, 1));
      m_b_pld[2]    = B_W'($urandom());
      s_b_ready[2]  = 1'($urandom_range(0, 1));
      s_ar_valid[2] = 1'($urandom_range(0, 1));
      s_ar_pld[2]   = AR_W'({$urandom(), $urandom()});
      m_ar_ready[2] = 1'($urandom_range(0, 1));
      m_r_valid[2]  = 1'($urandom_range(0, 1));
      m_r_pld[2]    = R_W'({$urandom(), $urandom(), $urandom()});
      s_r_ready[2]  = 1'($urandom_range(0, 1));
      #1;
      check("t6_aw", {m_aw_valid[2], m_aw_pld[2], s_aw_ready[2]}, {s_aw_valid[2], s_aw_pld[2], m_aw_ready[2]});
      check("t6_w",  {m_w_valid[2],  m_w_pld[2],  s_w_ready[2]},  {s_w_valid[2],  s_w_pld[2],  m_w_ready[2]});
      check("t6_b",  {s_b_valid[2],  s_b_pld[2],  m_b_ready[2]},  {m_b_valid[2],  m_b_pld[2],  s_b_ready[2]});
      check("t6_ar", {m_ar_valid[2], m_ar_pld[2], s_ar_ready[2]}, {s_ar_valid[2], s_ar_pld[2], m_ar_ready[2]});
      check("t6_r",  {s_r_valid[2],  s_r_pld[2],  m_r_ready[2]},  {m_r_valid[2],  m_r_pld[2],  s_r_ready[2]});
      if (s_aw_valid[2] && s_aw_ready[2]) sb_q.push_back(s_aw_pld[2]);
      if (m_aw_valid[2] && m_aw_ready[2]) begin
        check("t6_sb_nonempty", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          sb_exp = sb_q.pop_front();
          check("t6_sb_pld", m_aw_pld[2], sb_exp);
        end
      end
      tick();
    end
    check("t6_sb_left", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
